midi_tx: RTL and testbench

//  Serial MIDI OUT transmitter; the send-side counterpart of the MidiProc receiver. Accepts one

---
 rtl/midi_pkg.sv | 33 +++
 rtl/midi_byte_ser.sv | 107 ++++++++++
 rtl/midi_tx.sv | 122 ++++++++++++
 tb/tb_midi_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI OUT transmitter.
//   MIDI_BAUD          standard MIDI bit rate
//   CH_VOICE_MIN/SYS_MIN/RT_MIN  status byte range boundaries
//   tx_state_e         8N1 serialiser state
//   msg_len()          message length in bytes from the status byte (0 = reject)
package midi_pkg;

    localparam int unsigned MIDI_BAUD    = 31_250;
    localparam logic [7:0]  CH_VOICE_MIN = 8'h80;
    localparam logic [7:0]  SYS_MIN      = 8'hF0;
    localparam logic [7:0]  RT_MIN       = 8'hF8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    // Channel voice 8x..Ex carry 1 or 2 data bytes; realtime F8..FF is status only.
    // F0..F7 (sysex / system common) is not supported and is rejected.
    function automatic logic [1:0] msg_len(input logic [7:0] status);
        logic [1:0] len;
        if (status < CH_VOICE_MIN) begin
            len = 2'd0;
        end else if (status >= RT_MIN) begin
            len = 2'd1;
        end else if (status >= SYS_MIN) begin
            len = 2'd0;
        end else if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
            len = 2'd2;
        end else begin
            len = 2'd3;
        end
        return len;
    endfunction

endpackage

// File: rtl/midi_byte_ser.sv
// 8N1 byte serialiser with its own baud counter.
//   clk_i   system clock (rising edge)
//   rst_ni  synchronous active-low reset
//   load_i  start a new byte; taken in IDLE or on the last cycle of STOP
//   byte_i  byte to send, LSB first
//   done_o  high on the last cycle of the STOP bit
//   idle_o  serialiser in IDLE
//   line_o  serial line, idle high
module midi_byte_ser
    import midi_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 320
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic       idle_o,
    output logic       line_o
);

    localparam int unsigned      CNT_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             term;

    assign term = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = START;
                    cnt_d   = '0;
                    shift_d = byte_i;
                end
            end
            START: begin
                if (term) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (term) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (term) begin
                    done_o = 1'b1;
                    cnt_d  = '0;
                    // Chain straight into the next START so bytes go out back-to-back.
                    if (load_i) begin
                        state_d = START;
                        shift_d = byte_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign idle_o = (state_q == IDLE);
    assign line_o = (state_q == START) ? 1'b0 :
                    (state_q == DATA)  ? shift_q[0] : 1'b1;

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT transmitter: takes one message (status + up to two data bytes) per valid/ready
// handshake and sends it as 8N1 frames at BAUD.
//   clock, reset            system clock; synchronous active-low reset
//   io_en                   accept new messages when high
//   io_msg_valid/ready      message handshake
//   io_status/data1/data2   message fields, latched on transfer
//   io_midi_out             serial line, idle high
//   io_busy                 message being shifted
//   io_err                  one-cycle pulse after a rejected message
// Optional feature: define MIDI_RUNNING_STATUS_EN to omit a repeated channel-voice status byte.
module midi_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 10_000_000,
    parameter int unsigned BAUD     = MIDI_BAUD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_en,
    input  logic       io_msg_valid,
    output logic       io_msg_ready,
    input  logic [7:0] io_status,
    input  logic [6:0] io_data1,
    input  logic [6:0] io_data2,
    output logic       io_midi_out,
    output logic       io_busy,
    output logic       io_err
);

    localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;

    logic            ser_load, ser_done, ser_idle;
    logic [7:0]      ser_byte;
    logic [1:0]      len;
    logic            xfer, accept, reject, skip_status;
    logic [1:0]      rem_q, rem_d;
    logic [1:0][7:0] nxt_q, nxt_d;
    logic            err_q;

    assign len          = msg_len(io_status);
    assign io_msg_ready = reset && io_en && ser_idle;
    assign xfer         = io_msg_valid && io_msg_ready;
    assign accept       = xfer && (len != 2'd0);
    assign reject       = xfer && (len == 2'd0);

`ifdef MIDI_RUNNING_STATUS_EN
    // Last channel-voice status sent; 0 never matches a legal status.
    logic [7:0] rs_q, rs_d;

    assign skip_status = (len >= 2'd2) && (io_status == rs_q);

    always_comb begin
        rs_d = rs_q;
        if (accept && len >= 2'd2) begin
            rs_d = io_status;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rs_q <= 8'h00;
        end else begin
            rs_q <= rs_d;
        end
    end
`else
    assign skip_status = 1'b0;
`endif

    // First byte goes straight to the serialiser; the rest wait in nxt_q.
    always_comb begin
        ser_load = 1'b0;
        ser_byte = 8'h00;
        rem_d    = rem_q;
        nxt_d    = nxt_q;
        if (accept) begin
            ser_load = 1'b1;
            if (skip_status) begin
                ser_byte = {1'b0, io_data1};
                nxt_d[0] = {1'b0, io_data2};
            end else begin
                ser_byte = io_status;
                nxt_d[0] = {1'b0, io_data1};
            end
            nxt_d[1] = {1'b0, io_data2};
            rem_d    = len - 2'd1 - {1'b0, skip_status};
        end else if (ser_done && rem_q != 2'd0) begin
            ser_load = 1'b1;
            ser_byte = nxt_q[0];
            nxt_d[0] = nxt_q[1];
            rem_d    = rem_q - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_q <= 2'd0;
            nxt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            nxt_q <= nxt_d;
            err_q <= reject;
        end
    end

    midi_byte_ser #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_ser (
        .clk_i (clock),
        .rst_ni(reset),
        .load_i(ser_load),
        .byte_i(ser_byte),
        .done_o(ser_done),
        .idle_o(ser_idle),
        .line_o(io_midi_out)
    );

    assign io_busy = !ser_idle;
    assign io_err  = err_q;

endmodule

// File: tb/tb_midi_tx.sv
module tb_midi_tx;

    localparam int BIT   = 320;
    localparam int FRAME = 10 * BIT;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_en = 1'b1;
    logic       io_msg_valid = 1'b0;
    logic       io_msg_ready;
    logic [7:0] io_status = 8'h00;
    logic [6:0] io_data1 = 7'h00;
    logic [6:0] io_data2 = 7'h00;
    logic       io_midi_out;
    logic       io_busy;
    logic       io_err;

    midi_tx dut (
        .clock       (clock),
        .reset       (reset),
        .io_en       (io_en),
        .io_msg_valid(io_msg_valid),
        .io_msg_ready(io_msg_ready),
        .io_status   (io_status),
        .io_data1    (io_data1),
        .io_data2    (io_data2),
        .io_midi_out (io_midi_out),
        .io_busy     (io_busy),
        .io_err      (io_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         t0;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] rs_m   = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame monitor: pops the expected byte at the start bit, then checks the
    // first and last cycle of every bit period against {stop, byte, start}.
    logic       mon_act = 1'b0;
    int         mon_t0;
    logic [7:0] mon_b;
    logic [9:0] mon_first, mon_last;

    always @(negedge clock) begin
        int   off;
        exp_t e;
        if (!reset) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && io_midi_out === 1'b0) begin
                mon_act   = 1'b1;
                mon_t0    = cyc;
                mon_first = '0;
                mon_last  = '0;
                if (exp_q.size() == 0) begin
                    check_eq("frame_unexpected", exp_q.size(), 1);
                    mon_b = 8'h00;
                end else begin
                    e     = exp_q.pop_front();
                    mon_b = e.b;
                    check_eq("frame_start", cyc, e.t0);
                end
            end
            if (mon_act) begin
                off = cyc - mon_t0;
                if (off % BIT == 0)       mon_first[off / BIT] = io_midi_out;
                if (off % BIT == BIT - 1) mon_last[off / BIT]  = io_midi_out;
                if (off == FRAME - 1) begin
                    check_eq("frame_bits_first", mon_first, {1'b1, mon_b, 1'b0});
                    check_eq("frame_bits_last", mon_last, {1'b1, mon_b, 1'b0});
                    mon_act = 1'b0;
                end
            end
        end
    end

    function automatic int model_len(input logic [7:0] s);
        if (!s[7])        return 0;
        if (s >= 8'hF8)   return 1;
        if (s >= 8'hF0)   return 0;
        if (s[7:5] == 3'b110) return 2;
        return 3;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                        output int acc, output int nb);
        int         n;
        int         len;
        int         first;
        logic [7:0] bytes [3];
        exp_t       e;
        n = 0;
        while (io_msg_ready !== 1'b1 && n < 40000) begin
            @(negedge clock);
            n++;
        end
        check_eq("ready_wait", io_msg_ready, 1);
        io_status    = st;
        io_data1     = d1;
        io_data2     = d2;
        io_msg_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        io_msg_valid = 1'b0;
        acc   = cyc;
        len   = model_len(st);
        nb    = 0;
        first = 0;
        if (len != 0) begin
            bytes[0] = st;
            bytes[1] = {1'b0, d1};
            bytes[2] = {1'b0, d2};
`ifdef MIDI_RUNNING_STATUS_EN
            if (len >= 2 && st == rs_m) first = 1;
            if (len >= 2) rs_m = st;
`endif
            for (int k = first; k < len; k++) begin
                e.b  = bytes[k];
                e.t0 = acc + nb * FRAME;
                exp_q.push_back(e);
                nb++;
            end
        end
    endtask

    task automatic wait_msg(input int acc, input int nb);
        int dur;
        dur = nb * FRAME;
        check_eq("busy_first", io_busy, 1);
        while (cyc < acc + dur - 1) @(negedge clock);
        check_eq("busy_last", io_busy, 1);
        check_eq("ready_last", io_msg_ready, 0);
        @(negedge clock);
        check_eq("busy_end", io_busy, 0);
        check_eq("ready_back", io_msg_ready, io_en);
        check_eq("line_idle", io_midi_out, 1);
    endtask

    task automatic send_bad(input logic [7:0] st);
        int acc, nb;
        send(st, 7'h11, 7'h22, acc, nb);
        check_eq("err_pulse", io_err, 1);
        check_eq("rej_ready", io_msg_ready, 1);
        check_eq("rej_busy", io_busy, 0);
        check_eq("rej_line", io_midi_out, 1);
        @(negedge clock);
        check_eq("err_clear", io_err, 0);
        check_eq("rej_line2", io_midi_out, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, nb;
        repeat (3) @(negedge clock);
        check_eq("rst_line", io_midi_out, 1);
        check_eq("rst_ready", io_msg_ready, 0);
        check_eq("rst_busy", io_busy, 0);
        check_eq("rst_err", io_err, 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("ready_after_rst", io_msg_ready, 1);

        // Note-on: three frames, ready back at 9600.
        send(8'h90, 7'h3C, 7'h64, acc, nb);
        wait_msg(acc, nb);

        // Program change: data2 ignored.
        send(8'hC1, 7'h05, 7'h7F, acc, nb);
        check_eq("pc_err", io_err, 0);
        wait_msg(acc, nb);

        // Realtime clock.
        send(8'hF8, 7'h00, 7'h00, acc, nb);
        check_eq("rt_err", io_err, 0);
        wait_msg(acc, nb);
        check_eq("rt_err_end", io_err, 0);

        // Rejects.
        send_bad(8'hF2);
        send_bad(8'h3C);

        // Two note-ons with the same status.
        send(8'h90, 7'h3C, 7'h64, acc, nb);
        wait_msg(acc, nb);
        send(8'h90, 7'h40, 7'h64, acc, nb);
        wait_msg(acc, nb);

        // Valid while disabled: ignored, no error.
        io_en = 1'b0;
        @(negedge clock);
        check_eq("dis_ready", io_msg_ready, 0);
        io_status    = 8'h90;
        io_msg_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check_eq("dis_err", io_err, 0);
            check_eq("dis_busy", io_busy, 0);
        end
        io_msg_valid = 1'b0;
        io_en        = 1'b1;
        @(negedge clock);

        // Disable mid-message: message still completes.
        send(8'h80, 7'h3C, 7'h00, acc, nb);
        io_en = 1'b0;
        wait_msg(acc, nb);
        io_en = 1'b1;
        @(negedge clock);

        // Reset mid-DATA of byte 2.
        send(8'h90, 7'h3C, 7'h64, acc, nb);
        while (cyc < acc + FRAME + 4 * BIT) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        rs_m = 8'h00;
        @(negedge clock);
        check_eq("midrst_line", io_midi_out, 1);
        check_eq("midrst_busy", io_busy, 0);
        check_eq("midrst_ready", io_msg_ready, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("postrst_ready", io_msg_ready, 1);
        check_eq("postrst_line", io_midi_out, 1);
        send(8'h90, 7'h3C, 7'h64, acc, nb);
        wait_msg(acc, nb);

        repeat (5) @(negedge clock);
        check_eq("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
